// File: rtl/xbar_out_arbiter.sv
// rtl/xbar_out_arbiter.sv - round-robin, packet-locked output-port arbiter and mux for the stream crossbar
// Optional registered 2-entry skid buffer on the outputs: define XBAR_ARB_OUT_REG_EN.
module xbar_out_arbiter #(
    parameter int  S_DATA_COUNT = 2,
    parameter int  T_DATA_WIDTH = 8,
    localparam int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [S_DATA_COUNT-1:0],
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    output logic [S_DATA_COUNT-1:0] s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic [T_ID_WIDTH-1:0]   m_id_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [T_ID_WIDTH-1:0]   lock_id_q, lock_id_d;
    logic [T_ID_WIDTH-1:0]   last_gnt_q, last_gnt_d;
    logic [T_ID_WIDTH-1:0]   rr_gnt, gnt;
    logic                    v, hs, stage_ready;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic                    sel_last;

    // Round-robin search starting one past the last master that finished a packet.
    always_comb begin
        logic                  found;
        logic [T_ID_WIDTH-1:0] idx;
        rr_gnt = '0;
        found  = 1'b0;
        for (int k = 1; k <= S_DATA_COUNT; k++) begin
            idx = T_ID_WIDTH'((int'(last_gnt_q) + k) % S_DATA_COUNT);
            if (!found && req_i[idx]) begin
                rr_gnt = idx;
                found  = 1'b1;
            end
        end
    end

    // Valid is forced low during reset so nothing is offered or accepted.
    always_comb begin
        gnt = (state_q == LOCKED) ? lock_id_q : rr_gnt;
        v   = rst_n_i & ((state_q == LOCKED) ? req_i[lock_id_q] : |req_i);
    end

    assign sel_data  = s_data_i[gnt];
    assign sel_last  = s_last_i[gnt];
    assign hs        = v & stage_ready;
    assign s_ready_o = hs ? (S_DATA_COUNT'(1) << gnt) : '0;

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (sel_last) begin
                        last_gnt_d = gnt;
                    end else begin
                        state_d   = LOCKED;
                        lock_id_d = gnt;
                    end
                end
            end
            LOCKED: begin
                if (hs && sel_last) begin
                    state_d    = IDLE;
                    last_gnt_d = lock_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            lock_id_q  <= '0;
            last_gnt_q <= T_ID_WIDTH'(S_DATA_COUNT - 1);
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef XBAR_ARB_OUT_REG_EN
    logic                    head_v, tail_v, pop;
    logic [T_DATA_WIDTH-1:0] head_data, tail_data;
    logic                    head_last, tail_last;
    logic [T_ID_WIDTH-1:0]   head_id, tail_id;

    // Head drives the outputs; tail only fills when the head is stalled.
    assign stage_ready = ~tail_v;
    assign pop         = head_v & m_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_v    <= 1'b0;
            tail_v    <= 1'b0;
            head_data <= '0;
            tail_data <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
            head_id   <= '0;
            tail_id   <= '0;
        end else if (pop) begin
            if (tail_v) begin
                head_data <= tail_data;
                head_last <= tail_last;
                head_id   <= tail_id;
                tail_v    <= 1'b0;
            end else if (hs) begin
                head_data <= sel_data;
                head_last <= sel_last;
                head_id   <= gnt;
            end else begin
                head_v <= 1'b0;
            end
        end else if (hs) begin
            if (!head_v) begin
                head_data <= sel_data;
                head_last <= sel_last;
                head_id   <= gnt;
                head_v    <= 1'b1;
            end else begin
                tail_data <= sel_data;
                tail_last <= sel_last;
                tail_id   <= gnt;
                tail_v    <= 1'b1;
            end
        end
    end

    assign m_valid_o = head_v;
    assign m_data_o  = head_data;
    assign m_last_o  = head_last;
    assign m_id_o    = head_id;
`else
    assign stage_ready = m_ready_i;
    assign m_valid_o   = v;
    assign m_data_o    = sel_data;
    assign m_last_o    = sel_last;
    assign m_id_o      = gnt;
`endif

endmodule

// File: tb/tb_xbar_out_arbiter.sv
// tb/tb_xbar_out_arbiter.sv - directed, table-driven bench for xbar_out_arbiter (S_DATA_COUNT=3)
module tb_xbar_out_arbiter;
    localparam int S  = 3;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [S-1:0]   req, last, sready;
    logic [W-1:0]   data [S-1:0];
    logic [W-1:0]   mdata;
    logic           mlast, mvalid, mready;
    logic [IW-1:0]  mid;

    int checks = 0;
    int errors = 0;

    xbar_out_arbiter #(.S_DATA_COUNT(S), .T_DATA_WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .s_data_i(data), .s_last_i(last),
        .s_ready_o(sready), .m_data_o(mdata), .m_last_o(mlast), .m_id_o(mid),
        .m_valid_o(mvalid), .m_ready_i(mready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] last;
        logic       mr;
        logic       ev;
        logic [1:0] eid;
        logic [2:0] esr;
        logic       elast;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic mr);
        req    = r;
        last   = l;
        mready = mr;
    endtask

`ifdef XBAR_ARB_OUT_REG_EN
    logic [W-1:0] exp_q[$];
    int           sent, popped;
    logic [W-1:0] nxt;
`endif

    initial begin
        rst_n  = 1'b0;
        req    = 3'b111;
        last   = 3'b111;
        mready = 1'b1;
        for (int j = 0; j < S; j++) data[j] = '0;

        @(negedge clk);
        chk("reset_valid", 32'(mvalid), 32'd0);
        chk("reset_sready", 32'(sready), 32'd0);
        step();
        rst_n = 1'b1;

`ifndef XBAR_ARB_OUT_REG_EN
        // eid below is the round-robin choice from a reset pointer of 2
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1});
        tbl.push_back('{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b1, 2'd0, 3'b000, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1});
        tbl.push_back('{3'b010, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0});
        tbl.push_back('{3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0});
        tbl.push_back('{3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0});
        tbl.push_back('{3'b011, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1});
        tbl.push_back('{3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1});
        tbl.push_back('{3'b101, 3'b101, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1});
        tbl.push_back('{3'b101, 3'b101, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].last, tbl[i].mr);
            for (int j = 0; j < S; j++) data[j] = 8'(j * 16 + i % 16);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(mvalid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_sready", i), 32'(sready), 32'(tbl[i].esr));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_id", i), 32'(mid), 32'(tbl[i].eid));
                chk($sformatf("v%0d_data", i), 32'(mdata), 32'(8'(int'(tbl[i].eid) * 16 + i % 16)));
                chk($sformatf("v%0d_last", i), 32'(mlast), 32'(tbl[i].elast));
            end
            step();
        end

        // locked master 2 drops its request while master 0 waits
        drive(3'b100, 3'b000, 1'b1);
        data[2] = 8'h20;
        @(negedge clk);
        chk("stall_first_id", 32'(mid), 32'd2);
        chk("stall_first_sready", 32'(sready), 32'b100);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(3'b001, 3'b001, 1'b1);
            @(negedge clk);
            chk($sformatf("stall%0d_valid", c), 32'(mvalid), 32'd0);
            chk($sformatf("stall%0d_sready", c), 32'(sready), 32'd0);
            step();
        end
        drive(3'b101, 3'b100, 1'b1);
        data[2] = 8'h21;
        @(negedge clk);
        chk("stall_resume_id", 32'(mid), 32'd2);
        chk("stall_resume_data", 32'(mdata), 32'h21);
        chk("stall_resume_last", 32'(mlast), 32'd1);
        step();
        drive(3'b001, 3'b001, 1'b1);
        @(negedge clk);
        chk("stall_after_id", 32'(mid), 32'd0);
        chk("stall_after_sready", 32'(sready), 32'b001);
        step();

        // reset on beat 2 of a 4-beat packet from master 1
        drive(3'b010, 3'b000, 1'b1);
        data[1] = 8'h10;
        @(negedge clk);
        chk("rstpkt_beat1_id", 32'(mid), 32'd1);
        step();
        data[1] = 8'h11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstpkt_valid", 32'(mvalid), 32'd0);
        chk("rstpkt_sready", 32'(sready), 32'd0);
        step();
        rst_n = 1'b1;
        drive(3'b011, 3'b011, 1'b1);
        @(negedge clk);
        chk("rstpkt_after_id", 32'(mid), 32'd0);
        chk("rstpkt_after_sready", 32'(sready), 32'b001);
        step();
        @(negedge clk);
        chk("rstpkt_next_id", 32'(mid), 32'd1);
        step();
`else
        // one-cycle latency of a single beat
        drive(3'b001, 3'b001, 1'b1);
        data[0] = 8'hA5;
        @(negedge clk);
        chk("lat_valid_t0", 32'(mvalid), 32'd0);
        chk("lat_sready_t0", 32'(sready), 32'b001);
        step();
        drive(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        chk("lat_valid_t1", 32'(mvalid), 32'd1);
        chk("lat_data_t1", 32'(mdata), 32'hA5);
        chk("lat_id_t1", 32'(mid), 32'd0);
        chk("lat_last_t1", 32'(mlast), 32'd1);
        step();
        @(negedge clk);
        chk("lat_valid_t2", 32'(mvalid), 32'd0);

        // master 0 streams 6 beats; downstream stalls for the first 5 cycles
        sent   = 0;
        popped = 0;
        nxt    = 8'h40;
        for (int c = 0; c < 30 && (sent < 6 || exp_q.size() != 0); c++) begin
            step();
            drive((sent < 6) ? 3'b001 : 3'b000, 3'b001, (c >= 5) ? 1'b1 : 1'b0);
            data[0] = nxt;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("bp%0d_sready", c), 32'(sready), 32'd0);
                chk($sformatf("bp%0d_data", c), 32'(mdata), 32'h40);
                chk($sformatf("bp%0d_valid", c), 32'(mvalid), 32'd1);
            end
            if (mvalid && mready) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("bp%0d_spurious", c), 32'(mdata), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("bp%0d_order", c), 32'(mdata), 32'(exp_q.pop_front()));
                    popped++;
                end
            end
            if (sready[0]) begin
                exp_q.push_back(nxt);
                nxt = nxt + 8'd1;
                sent++;
            end
            if (c == 4) chk("bp_absorbed", 32'(sent), 32'd2);
        end
        chk("bp_popped", 32'(popped), 32'd6);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
